// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the serial pattern detector.
package seq_det_pkg;

  typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

  localparam int          DEF_PAT_W   = 3;
  localparam int          DEF_CNT_W   = 10;
  localparam logic [15:0] DEF_PAT_RST = 16'b010;

  // Fill counter must hold 0..PAT_W inclusive.
  function automatic int fill_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Match counter with synchronous clear; saturates when SEQ_DET_SAT_EN is defined, wraps otherwise.
module sat_counter #(
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  localparam logic [CNT_W-1:0] MAX = '1;

  // Clear is applied before the increment, so clr+inc lands on 1.
  logic [CNT_W-1:0] base;
  assign base = clr ? '0 : count;

`ifdef SEQ_DET_SAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      sat   <= 1'b0;
    end else begin
      if (inc && base != MAX) count <= base + CNT_W'(1);
      else                    count <= base;
      sat <= (clr ? 1'b0 : sat) | (inc && base == MAX - CNT_W'(1));
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count <= '0;
    else     count <= base + CNT_W'(inc);
  end
  assign sat = 1'b0;
`endif

endmodule

// File: rtl/seq_detector_cnt.sv
// Serial pattern detector with loadable pattern, overlap select and match counter.
// Optional saturating counter behaviour is selected by the SEQ_DET_SAT_EN macro.
module seq_detector_cnt
  import seq_det_pkg::*;
#(
  parameter int             PAT_W   = DEF_PAT_W,
  parameter int             CNT_W   = DEF_CNT_W,
  parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(DEF_PAT_RST)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             x,
  input  logic             load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             overlap,
  input  logic             clr_count,
  output logic             y,
  output logic [CNT_W-1:0] count,
  output logic             sat,
  output logic             busy
);

  localparam int FW = fill_w(PAT_W);

  state_t           state;
  logic [PAT_W-1:0] pat, hist, hist_n;
  logic [FW-1:0]    fill;
  logic             match;

  assign hist_n = {hist[PAT_W-2:0], x};

  // fill >= PAT_W-1 before the edge means this sample completes a full window.
  assign match = en && !load && (fill >= FW'(PAT_W - 1)) && (hist_n == pat);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pat   <= PAT_RST;
      hist  <= '0;
      fill  <= '0;
      y     <= 1'b0;
    end else begin
      y <= match;
      if (load) begin
        pat   <= pat_in;
        hist  <= '0;
        fill  <= '0;
        state <= ARM;
      end else if (en) begin
        if (match && !overlap) begin
          hist  <= '0;
          fill  <= '0;
          state <= ARM;
        end else begin
          hist <= hist_n;
          if (fill < FW'(PAT_W)) fill <= fill + FW'(1);
          state <= (fill >= FW'(PAT_W - 1)) ? RUN : ARM;
        end
      end
    end
  end

  assign busy = (state != IDLE);

  sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (match),
    .clr   (clr_count),
    .count (count),
    .sat   (sat)
  );

endmodule

// File: tb/tb_seq_detector_cnt.sv
// Bench for seq_detector_cnt: directed scenarios plus random traffic against a queue-based model.
module tb_seq_detector_cnt;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, x = 1'b0, load = 1'b0, overlap = 1'b0, clr_count = 1'b0;
  logic [2:0] pat_in = 3'b000;

  logic       y_a, sat_a, busy_a;
  logic [9:0] count_a;
  logic       y_b, sat_b, busy_b;
  logic [1:0] count_b;

  int checks = 0;
  int failures = 0;

  // Reference state: sampled bits since the last restart, oldest first.
  bit       hq[$];
  bit [2:0] mpat;
  bit       started;
  bit       exp_y;
  int       c10, c2;
  bit       s10, s2;

  always #5 clk = ~clk;

  seq_detector_cnt #(.PAT_W(3), .CNT_W(10)) u_a (
    .clk(clk), .rst(rst), .en(en), .x(x), .load(load), .pat_in(pat_in),
    .overlap(overlap), .clr_count(clr_count),
    .y(y_a), .count(count_a), .sat(sat_a), .busy(busy_a)
  );

  seq_detector_cnt #(.PAT_W(3), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .en(en), .x(x), .load(load), .pat_in(pat_in),
    .overlap(overlap), .clr_count(clr_count),
    .y(y_b), .count(count_b), .sat(sat_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic bump(inout int c, inout bit s, input int maxv);
`ifdef SEQ_DET_SAT_EN
    if (c < maxv) c++;
    if (c == maxv) s = 1'b1;
`else
    c = (c == maxv) ? 0 : c + 1;
    s = 1'b0;
`endif
  endtask

  task automatic model_reset();
    hq.delete();
    mpat = 3'b010;
    started = 1'b0;
    exp_y = 1'b0;
    c10 = 0; c2 = 0; s10 = 1'b0; s2 = 1'b0;
  endtask

  task automatic model_step();
    exp_y = 1'b0;
    if (load) begin
      mpat = pat_in;
      hq.delete();
      started = 1'b1;
    end else if (en) begin
      started = 1'b1;
      hq.push_back(x);
      if (hq.size() > 3) void'(hq.pop_front());
      if (hq.size() == 3 && {hq[0], hq[1], hq[2]} == mpat) begin
        exp_y = 1'b1;
        if (!overlap) hq.delete();
      end
    end
    if (clr_count) begin
      c10 = 0; c2 = 0; s10 = 1'b0; s2 = 1'b0;
    end
    if (exp_y) begin
      bump(c10, s10, 1023);
      bump(c2, s2, 3);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".y_a"},     32'(y_a),     32'(exp_y));
    chk({tag, ".count_a"}, 32'(count_a), 32'(c10));
    chk({tag, ".sat_a"},   32'(sat_a),   32'(s10));
    chk({tag, ".busy_a"},  32'(busy_a),  32'(started));
    chk({tag, ".y_b"},     32'(y_b),     32'(exp_y));
    chk({tag, ".count_b"}, 32'(count_b), 32'(c2));
    chk({tag, ".sat_b"},   32'(sat_b),   32'(s2));
  endtask

  task automatic cyc(input string tag, input bit e, input bit xb, input bit ov,
                     input bit ld = 1'b0, input bit [2:0] p = 3'b000, input bit cl = 1'b0);
    en = e; x = xb; overlap = ov; load = ld; pat_in = p; clr_count = cl;
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;
    cyc("idle", 1'b0, 1'b1, 1'b0);

    // Scenario 1: default pattern 010, overlapping.
    cyc("s1", 1, 0, 1); cyc("s1", 1, 1, 1); cyc("s1", 1, 0, 1);
    cyc("s1", 1, 1, 1); cyc("s1", 1, 0, 1);
    cyc("s1_tail", 0, 0, 1);
    chk("s1_count_const", 32'(count_a), 32'd2);

    // Scenario 2: same stream, non-overlapping.
    async_reset("s2_rst");
    cyc("s2", 1, 0, 0); cyc("s2", 1, 1, 0); cyc("s2", 1, 0, 0);
    cyc("s2", 1, 1, 0); cyc("s2", 1, 0, 0);
    cyc("s2_tail", 0, 0, 0);
    chk("s2_count_const", 32'(count_a), 32'd1);

    // Scenario 3: load 111 mid-stream, then ones with overlap.
    cyc("s3", 1, 1, 1); cyc("s3", 1, 1, 1);
    cyc("s3_load", 1, 1, 1, 1'b1, 3'b111);
    repeat (4) cyc("s3", 1, 1, 1);
    chk("s3_count_const", 32'(count_a), 32'd3);

    // Scenario 4: five matches on the 2-bit counter instance.
    async_reset("s4_rst");
    cyc("s4_load", 0, 0, 1, 1'b1, 3'b111);
    repeat (7) cyc("s4", 1, 1, 1);
`ifdef SEQ_DET_SAT_EN
    chk("s4_count_b_const", 32'(count_b), 32'd3);
    chk("s4_sat_b_const",   32'(sat_b),   32'd1);
`else
    chk("s4_count_b_const", 32'(count_b), 32'd1);
    chk("s4_sat_b_const",   32'(sat_b),   32'd0);
`endif

    // Scenario 5: clear coincides with a completing match at count=4.
    async_reset("s5_rst");
    cyc("s5", 1, 0, 1);
    repeat (4) begin cyc("s5", 1, 1, 1); cyc("s5", 1, 0, 1); end
    chk("s5_pre_count_const", 32'(count_a), 32'd4);
    cyc("s5", 1, 1, 1);
    cyc("s5_clr", 1, 0, 1, 1'b0, 3'b000, 1'b1);
    chk("s5_count_const", 32'(count_a), 32'd1);
    chk("s5_y_const",     32'(y_a),     32'd1);

    // Scenario 6: reset aborts a partial 0,1 prefix.
    cyc("s6", 1, 0, 0); cyc("s6", 1, 1, 0);
    async_reset("s6_rst");
    cyc("s6_idle", 0, 0, 0);
    cyc("s6_post", 1, 0, 0);
    chk("s6_y_const", 32'(y_a), 32'd0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cyc("rand",
          ($urandom_range(99) < 75),
          1'($urandom_range(1)),
          1'($urandom_range(1)),
          ($urandom_range(99) < 5),
          3'($urandom_range(7)),
          ($urandom_range(99) < 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
